// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: control word width, phase-FSM encoding and sign meaning
// used by the phase detector, loop filter and DCO.
package adpll_pkg;
  localparam int CTRL_W = 5;
  localparam logic [CTRL_W-1:0] CTRL_MAX = 5'd31;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REF_LEAD = 2'd1;
  localparam logic [1:0] DCO_LEAD = 2'd2;

  localparam logic SIGN_REF_LEADS = 1'b0;
  localparam logic SIGN_DCO_LEADS = 1'b1;
endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous input into the clk domain and emits a registered
// one-cycle pulse on each rising edge, SYNC_STAGES+1 cycles after the pin.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_qq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_qq <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      sync_qq <= sync_p0[SYNC_STAGES-1];
      rise    <= sync_p0[SYNC_STAGES-1] & ~sync_qq;
    end
  end

endmodule

// File: rtl/pfd_tdc_5bit.sv
// Phase/frequency detector with cycle-counting TDC: timestamps ref and dco rising
// edges, reports a signed 5-bit phase error per edge pair and tracks lock.
module pfd_tdc_5bit
  import adpll_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 31,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ref_in,
  input  logic              dco_in,
  output logic              ctrl_sign,
  output logic [CTRL_W-1:0] ctrl,
  output logic              err_valid,
  output logic              err_timeout,
  output logic              locked
);

  localparam logic [CTRL_W-1:0] TIMEOUT_C  = CTRL_W'(TIMEOUT);
  localparam logic [CTRL_W-1:0] LOCK_TOL_C = CTRL_W'(LOCK_TOL);
  localparam logic [3:0]        LOCK_CNT_C = 4'(LOCK_CNT);

  function automatic logic [CTRL_W-1:0] sat_inc(input logic [CTRL_W-1:0] v);
    return (v == CTRL_MAX) ? CTRL_MAX : v + 1'b1;
  endfunction

  function automatic logic [3:0] sat_good(input logic [3:0] v);
    return (v >= LOCK_CNT_C) ? LOCK_CNT_C : v + 1'b1;
  endfunction

  logic              ref_e, dco_e;
  logic [1:0]        state, state_nxt;
  logic [CTRL_W-1:0] counter, cnt_nxt;
  logic              vld_p0, to_p0, sign_p0;
  logic [CTRL_W-1:0] mag_p0;
  logic              lead_dco, opp_e;
  logic [3:0]        good_cnt;
  logic              good_res;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk(clk), .reset(reset), .d(ref_in), .rise(ref_e)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dco_sync (
    .clk(clk), .reset(reset), .d(dco_in), .rise(dco_e)
  );

  // Stage p0: edge-pair measurement. A repeat of the leading edge is simply not looked at.
  assign lead_dco = (state == DCO_LEAD);
  assign opp_e    = lead_dco ? ref_e : dco_e;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = counter;
    vld_p0    = 1'b0;
    to_p0     = 1'b0;
    sign_p0   = SIGN_REF_LEADS;
    mag_p0    = '0;
    case (state)
      IDLE: begin
        if (ref_e && dco_e) begin
          vld_p0 = 1'b1;
        end else if (ref_e) begin
          state_nxt = REF_LEAD;
          cnt_nxt   = 5'd1;
        end else if (dco_e) begin
          state_nxt = DCO_LEAD;
          cnt_nxt   = 5'd1;
        end
      end
      REF_LEAD, DCO_LEAD: begin
        sign_p0 = lead_dco ? SIGN_DCO_LEADS : SIGN_REF_LEADS;
        if (opp_e || counter == TIMEOUT_C) begin
          vld_p0    = 1'b1;
          to_p0     = ~opp_e;
          mag_p0    = counter;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(counter);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= cnt_nxt;
    end
  end

  // Stage p1: registered result, held until the next measurement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_valid   <= 1'b0;
      err_timeout <= 1'b0;
      ctrl        <= '0;
      ctrl_sign   <= SIGN_REF_LEADS;
    end else begin
      err_valid   <= vld_p0;
      err_timeout <= to_p0;
      if (vld_p0) begin
        ctrl      <= mag_p0;
        ctrl_sign <= sign_p0;
      end
    end
  end

  // Stage p2: lock tracking on each registered result.
  assign good_res = !err_timeout && (ctrl <= LOCK_TOL_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (err_valid) begin
      if (good_res) begin
        good_cnt <= sat_good(good_cnt);
        locked   <= (sat_good(good_cnt) == LOCK_CNT_C);
      end else begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pfd_tdc_5bit.sv
// Directed bench for pfd_tdc_5bit: vector table of edge pairs plus hand-built
// sequences for repeat edges, timeout, lock and mid-measurement reset.
module tb_pfd_tdc_5bit;

  localparam int SYNC = 2;

  logic       clk, reset, ref_in, dco_in;
  logic       ctrl_sign, err_valid, err_timeout, locked;
  logic [4:0] ctrl;

  pfd_tdc_5bit #(.SYNC_STAGES(SYNC), .TIMEOUT(31), .LOCK_TOL(1), .LOCK_CNT(8)) dut (
    .clk(clk), .reset(reset), .ref_in(ref_in), .dco_in(dco_in),
    .ctrl_sign(ctrl_sign), .ctrl(ctrl), .err_valid(err_valid),
    .err_timeout(err_timeout), .locked(locked)
  );

  typedef struct {
    int cyc;
    int mag;
    int sgn;
    int to;
    int lk;
  } res_t;

  typedef struct {
    bit lead_ref;
    int gap;
    int e_mag;
    int e_sgn;
  } vec_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  res_t resq[$];
  int   lockq[$];
  bit   ev_d = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ev_d) lockq.push_back(int'(locked));
    if (err_valid)
      resq.push_back('{cyc, int'(ctrl), int'(ctrl_sign), int'(err_timeout), int'(locked)});
    ev_d = err_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pair(input bit lead_ref, input int gap, output int t0);
    t0 = cyc;
    for (int i = 0; i < gap + 7; i++) begin
      bit l, o;
      l = (i < 3);
      o = (i >= gap) && (i < gap + 3);
      ref_in = lead_ref ? l : o;
      dco_in = lead_ref ? o : l;
      step();
    end
    ref_in = 1'b0;
    dco_in = 1'b0;
  endtask

  task automatic get_result(output res_t r, output int lk_after, output bit ok);
    int w = 0;
    while ((resq.size() == 0 || lockq.size() == 0) && w < 80) begin
      step();
      w++;
    end
    ok = (resq.size() != 0) && (lockq.size() != 0);
    if (ok) begin
      r        = resq.pop_front();
      lk_after = lockq.pop_front();
    end else begin
      r        = '{0, 0, 0, 0, 0};
      lk_after = 0;
      check("result_wait", 0, 1);
    end
  endtask

  vec_t vt[7];
  res_t r;
  int   t0, lk_after;
  bit   ok;

  initial begin
    vt[0] = '{1'b1, 4, 4, 0};
    vt[1] = '{1'b0, 7, 7, 1};
    vt[2] = '{1'b1, 0, 0, 0};
    vt[3] = '{1'b1, 1, 1, 0};
    vt[4] = '{1'b0, 2, 2, 1};
    vt[5] = '{1'b1, 31, 31, 0};
    vt[6] = '{1'b0, 12, 12, 1};

    reset  = 1'b0;
    ref_in = 1'b0;
    dco_in = 1'b0;
    step();

    // Reset held with toggling inputs; inputs parked low before release.
    for (int i = 0; i < 5; i++) begin
      ref_in = (i < 4) ? i[0] : 1'b0;
      dco_in = (i < 4) ? ~i[0] : 1'b0;
      step();
      check("reset_outputs", int'({ctrl_sign, ctrl, err_valid, err_timeout, locked}), 0);
    end
    reset = 1'b1;
    step();
    check("post_reset_outputs", int'({ctrl_sign, ctrl, err_valid, err_timeout, locked}), 0);
    check("reset_no_result", resq.size(), 0);

    foreach (vt[k]) begin
      pair(vt[k].lead_ref, vt[k].gap, t0);
      idle(4);
      get_result(r, lk_after, ok);
      if (ok) begin
        check($sformatf("vec%0d_ctrl", k), r.mag, vt[k].e_mag);
        check($sformatf("vec%0d_sign", k), r.sgn, vt[k].e_sgn);
        check($sformatf("vec%0d_timeout", k), r.to, 0);
        check($sformatf("vec%0d_latency", k), r.cyc - t0, SYNC + 2 + vt[k].gap);
      end
      check($sformatf("vec%0d_single_result", k), resq.size(), 0);
    end

    // DCO leads by 7; a second dco rise 3 cycles in is ignored.
    t0 = cyc;
    for (int i = 0; i < 14; i++) begin
      dco_in = (i == 0) || (i == 3);
      ref_in = (i >= 7) && (i < 10);
      step();
    end
    ref_in = 1'b0;
    dco_in = 1'b0;
    idle(4);
    get_result(r, lk_after, ok);
    if (ok) begin
      check("repeat_ctrl", r.mag, 7);
      check("repeat_sign", r.sgn, 1);
      check("repeat_latency", r.cyc - t0, SYNC + 2 + 7);
    end
    check("repeat_single_result", resq.size(), 0);

    // Ref leads, dco absent 40 cycles: timeout, then dco starts a new measurement.
    t0 = cyc;
    for (int i = 0; i < 56; i++) begin
      ref_in = (i < 3) || ((i >= 46) && (i < 49));
      dco_in = (i >= 40) && (i < 43);
      step();
    end
    ref_in = 1'b0;
    dco_in = 1'b0;
    idle(4);
    get_result(r, lk_after, ok);
    if (ok) begin
      check("timeout_ctrl", r.mag, 31);
      check("timeout_sign", r.sgn, 0);
      check("timeout_flag", r.to, 1);
      check("timeout_latency", r.cyc - t0, SYNC + 2 + 31);
    end
    get_result(r, lk_after, ok);
    if (ok) begin
      check("after_timeout_ctrl", r.mag, 6);
      check("after_timeout_sign", r.sgn, 1);
      check("after_timeout_flag", r.to, 0);
      check("after_timeout_latency", r.cyc - t0, SYNC + 2 + 46);
    end
    check("timeout_result_count", resq.size(), 0);

    // Lock: fresh start, eight results of 1, then one of 5.
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    resq.delete();
    lockq.delete();
    step();
    for (int k = 0; k < 8; k++) begin
      pair(1'b1, 1, t0);
      idle(2);
      get_result(r, lk_after, ok);
      if (ok) begin
        check($sformatf("lock_pair%0d_ctrl", k), r.mag, 1);
        if (k == 6) check("lock_after_7th", lk_after, 0);
        if (k == 7) begin
          check("lock_at_8th", r.lk, 0);
          check("lock_after_8th", lk_after, 1);
        end
      end
    end
    check("locked_held", int'(locked), 1);
    pair(1'b1, 5, t0);
    idle(2);
    get_result(r, lk_after, ok);
    if (ok) begin
      check("unlock_ctrl", r.mag, 5);
      check("lock_at_9th", r.lk, 1);
      check("lock_after_9th", lk_after, 0);
    end

    // Reset pulsed while in REF_LEAD: the measurement vanishes.
    for (int i = 0; i < 6; i++) begin
      ref_in = (i < 3);
      step();
    end
    ref_in = 1'b0;
    reset  = 1'b0;
    step();
    reset = 1'b1;
    idle(40);
    check("abort_no_result", resq.size(), 0);
    check("abort_locked", int'(locked), 0);
    check("abort_err_valid", int'(err_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
